// File: rtl/video_mixer_sl.sv
// Video output stage: depth expansion, scanlines, ce_pix type detection, registered syncs/DE.
// Define VIDEO_MIXER_SL_SCANLINES_EN to build in odd-line scanline darkening.
module video_mixer_sl #(
  parameter int IN_DW = 8
) (
  input  logic             CLK_VIDEO,
  input  logic             RESET_N,
  input  logic             ce_pix,
  input  logic [1:0]       sl_mode,
  input  logic             freeze,
  input  logic [IN_DW-1:0] R,
  input  logic [IN_DW-1:0] G,
  input  logic [IN_DW-1:0] B,
  input  logic             HSync,
  input  logic             VSync,
  input  logic             HBlank,
  input  logic             VBlank,
  output logic             CE_PIXEL,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_DE
);

  localparam int REP = (8 + IN_DW - 1) / IN_DW;

  function automatic logic [7:0] expand(input logic [IN_DW-1:0] c);
    logic [REP*IN_DW-1:0] t;
    t = {REP{c}};
    return t[REP*IN_DW-1 -: 8];
  endfunction

  logic ce_d, vs_d, run2, clkmode;
  logic fr1, fr2;
  logic vs_rise, ce_int;

  assign vs_rise = VSync & ~vs_d;
  assign ce_int  = clkmode ? (ce_pix & ~ce_d) : ce_pix;

  // A 2-clock-high ce_pix run in a frame selects clock mode for the next one
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      ce_d    <= 1'b0;
      vs_d    <= 1'b0;
      run2    <= 1'b0;
      clkmode <= 1'b0;
      fr1     <= 1'b0;
      fr2     <= 1'b0;
    end else begin
      ce_d <= ce_pix;
      vs_d <= VSync;
      fr1  <= freeze;
      fr2  <= fr1;
      if (vs_rise) begin
        clkmode <= run2;
        run2    <= 1'b0;
      end else if (ce_pix & ce_d) begin
        run2 <= 1'b1;
      end
    end
  end

  logic [7:0] r_x, g_x, b_x;
  assign r_x = fr2 ? 8'h00 : expand(R);
  assign g_x = fr2 ? 8'h00 : expand(G);
  assign b_x = fr2 ? 8'h00 : expand(B);

  logic [7:0] a_r, a_g, a_b;
  logic       a_hs, a_vs, a_hde, a_vde, old_hde;
  logic [7:0] o_r, o_g, o_b;

`ifdef VIDEO_MIXER_SL_SCANLINES_EN
  logic       hs_p, odd;
  logic [1:0] sl_q;

  function automatic logic [7:0] scan(
    input logic [7:0] c,
    input logic       o,
    input logic [1:0] m
  );
    logic [7:0] s;
    s = c;
    if (o) begin
      case (m)
        2'd1:    s = c - {2'b00, c[7:2]};
        2'd2:    s = {1'b0, c[7:1]};
        2'd3:    s = {2'b00, c[7:2]};
        default: s = c;
      endcase
    end
    return s;
  endfunction

  // Frame start clears parity even if an HSync edge lands on the same clock
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_p <= 1'b0;
      odd  <= 1'b0;
      sl_q <= 2'd0;
    end else begin
      if (ce_int) hs_p <= HSync;
      if (vs_rise) begin
        odd  <= 1'b0;
        sl_q <= sl_mode;
      end else if (ce_int & HSync & ~hs_p) begin
        odd <= ~odd;
      end
    end
  end

  assign o_r = scan(a_r, odd, sl_q);
  assign o_g = scan(a_g, odd, sl_q);
  assign o_b = scan(a_b, odd, sl_q);
`else
  logic sl_unused;
  assign sl_unused = ^sl_mode;
  assign o_r = a_r;
  assign o_g = a_g;
  assign o_b = a_b;
`endif

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      a_r     <= 8'h00;
      a_g     <= 8'h00;
      a_b     <= 8'h00;
      a_hs    <= 1'b0;
      a_vs    <= 1'b0;
      a_hde   <= 1'b0;
      a_vde   <= 1'b0;
      old_hde <= 1'b0;
      VGA_R   <= 8'h00;
      VGA_G   <= 8'h00;
      VGA_B   <= 8'h00;
      VGA_HS  <= 1'b0;
      VGA_VS  <= 1'b0;
      VGA_DE  <= 1'b0;
    end else if (ce_int) begin
      a_r     <= r_x;
      a_g     <= g_x;
      a_b     <= b_x;
      a_hs    <= HSync;
      a_vs    <= VSync;
      a_hde   <= ~HBlank;
      a_vde   <= ~VBlank;
      VGA_R   <= o_r;
      VGA_G   <= o_g;
      VGA_B   <= o_b;
      VGA_HS  <= a_hs;
      VGA_VS  <= a_vs;
      old_hde <= a_hde;
      // DE only moves at horizontal blank edges
      if (a_hde != old_hde) VGA_DE <= a_hde & a_vde;
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) CE_PIXEL <= 1'b0;
    else          CE_PIXEL <= ce_int;
  end

endmodule
